// File: rtl/fpdiv_arbiter.sv
// Round-robin arbiter sharing one multicycle combinational FP divider.
// Optional flush port enabled by defining FPDIV_ARB_FLUSH_EN.

module FPDiv #(
   parameter int W = 64
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] q
);
   localparam int EW   = (W == 64) ? 11 : 8;
   localparam int MW   = W - EW - 1;
   localparam int BIAS = (1 << (EW - 1)) - 1;

   logic          sa, sb, sq;
   logic [EW-1:0] ea, eb;
   logic [MW-1:0] fa, fb, mant;
   logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [2*MW+3:0] num, den;
   logic [MW+3:0] quo;
   logic          norm, guard, stick, rnd, ovf, unf;
   logic [EW+1:0] ex;
   logic [W-2:0]  body;

   assign {sa, ea, fa} = a;
   assign {sb, eb, fb} = b;
   assign sq = sa ^ sb;

   // Subnormal operands are treated as zero; tiny results flush to zero.
   assign a_nan  = (&ea) && (|fa);
   assign b_nan  = (&eb) && (|fb);
   assign a_inf  = (&ea) && !(|fa);
   assign b_inf  = (&eb) && !(|fb);
   assign a_zero = ~|ea;
   assign b_zero = ~|eb;

   assign num  = {1'b1, fa, {(MW+3){1'b0}}};
   assign den  = {{(MW+3){1'b0}}, 1'b1, fb};
   assign quo  = (MW+4)'(num / den);
   assign norm = quo[MW+3];

   assign mant  = norm ? quo[MW+2:3] : quo[MW+1:2];
   assign guard = norm ? quo[2] : quo[1];
   assign stick = (norm ? (|quo[1:0]) : quo[0]) | (|(num % den));
   assign rnd   = guard & (stick | mant[0]);

   assign ex = {2'b00, ea} - {2'b00, eb} + (EW+2)'(BIAS)
             - {{(EW+1){1'b0}}, ~norm};
   assign ovf = !ex[EW+1] && (ex[EW] || (&ex[EW-1:0]));
   assign unf = ex[EW+1] || (ex == '0);

   // A rounding carry ripples into the exponent, reaching inf if needed.
   assign body = {ex[EW-1:0], mant} + (W-1)'(rnd);

   always_comb begin
      q = {sq, body};
      if (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero))
         q = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      else if (a_inf | b_zero)
         q = {sq, {EW{1'b1}}, {MW{1'b0}}};
      else if (a_zero | b_inf)
         q = {sq, {(W-1){1'b0}}};
      else if (ovf)
         q = {sq, {EW{1'b1}}, {MW{1'b0}}};
      else if (unf)
         q = {sq, {(W-1){1'b0}}};
   end
endmodule

module fpdiv_arbiter #(
   parameter int BUS_WIDTH  = 64,
   parameter int NUM_REQ    = 2,
   parameter int DIV_CYCLES = 4,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                           clk,
   input  logic                           rst,
`ifdef FPDIV_ARB_FLUSH_EN
   input  logic                           flush,
`endif
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_in1,
   input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_in2,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [BUS_WIDTH-1:0]           resp_data,
   output logic [$clog2(NUM_REQ)-1:0]     resp_id,
   output logic [TAG_WIDTH-1:0]           resp_tag,
   output logic                           busy
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(DIV_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state, state_d;
   logic [IW-1:0]        rr_ptr, op_id, gid;
   logic [IW:0]          idx;
   logic [CW-1:0]        count;
   logic [BUS_WIDTH-1:0] op1, op2, sel1, sel2, quot;
   logic [TAG_WIDTH-1:0] op_tag, sel_tag;
   logic [NUM_REQ-1:0]   grant;
   logic                 found, accept, do_flush, load_resp, clr_resp;

`ifdef FPDIV_ARB_FLUSH_EN
   assign do_flush = flush;
`else
   assign do_flush = 1'b0;
`endif

   always_comb begin
      grant = '0;
      gid   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = {1'b0, rr_ptr} + (IW+1)'(i);
         if (idx >= (IW+1)'(NUM_REQ))
            idx = idx - (IW+1)'(NUM_REQ);
         if (!found && req_valid[idx[IW-1:0]]) begin
            found = 1'b1;
            gid   = idx[IW-1:0];
            grant[idx[IW-1:0]] = 1'b1;
         end
      end
   end

   always_comb begin
      sel1    = '0;
      sel2    = '0;
      sel_tag = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel1    = req_in1[i*BUS_WIDTH +: BUS_WIDTH];
            sel2    = req_in2[i*BUS_WIDTH +: BUS_WIDTH];
            sel_tag = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
         end
      end
   end

   assign req_ready = (state == IDLE && !rst && !do_flush) ? grant : '0;
   assign accept    = |req_ready;
   assign busy      = (state != IDLE);

   always_comb begin
      state_d   = state;
      load_resp = 1'b0;
      clr_resp  = 1'b0;
      unique case (state)
         IDLE: if (accept) state_d = BUSY;
         BUSY: begin
            if (do_flush) begin
               state_d = IDLE;
            end else if (count == '0) begin
               state_d   = DONE;
               load_resp = 1'b1;
            end
         end
         DONE: begin
            if (do_flush || resp_ready) begin
               state_d  = IDLE;
               clr_resp = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr     <= IW'(NUM_REQ - 1);
         count      <= '0;
         op1        <= '0;
         op2        <= '0;
         op_tag     <= '0;
         op_id      <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= '0;
         resp_tag   <= '0;
      end else begin
         if (accept) begin
            op1    <= sel1;
            op2    <= sel2;
            op_tag <= sel_tag;
            op_id  <= gid;
            rr_ptr <= gid;
            count  <= CW'(DIV_CYCLES - 1);
         end else if (state == BUSY) begin
            count <= (do_flush || count == '0) ? '0 : count - CW'(1);
         end
         if (load_resp) begin
            resp_valid <= 1'b1;
            resp_data  <= quot;
            resp_id    <= op_id;
            resp_tag   <= op_tag;
         end else if (clr_resp) begin
            resp_valid <= 1'b0;
         end
      end
   end

   // Divider sees only the latched operands for the whole BUSY window.
   FPDiv #(.W(BUS_WIDTH)) u_div (
      .a (op1),
      .b (op2),
      .q (quot)
   );
endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Randomized self-checking bench for fpdiv_arbiter.
// Reference divides with host reals and tracks round-robin order.

module tb_fpdiv_arbiter;
   localparam int BW = 64;
   localparam int N  = 2;
   localparam int D  = 4;
   localparam int TW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*BW-1:0] req_in1, req_in2;
   logic [N*TW-1:0] req_tag;
   logic            resp_valid, resp_ready;
   logic [BW-1:0]   resp_data;
   logic [$clog2(N)-1:0] resp_id;
   logic [TW-1:0]   resp_tag;
   logic            busy;
`ifdef FPDIV_ARB_FLUSH_EN
   logic            flush = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int model_last = N - 1;

   always #5 clk = ~clk;

   fpdiv_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(N), .DIV_CYCLES(D),
                   .TAG_WIDTH(TW)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef FPDIV_ARB_FLUSH_EN
      .flush      (flush),
`endif
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_in1    (req_in1),
      .req_in2    (req_in2),
      .req_tag    (req_tag),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .resp_tag   (resp_tag),
      .busy       (busy)
   );

   function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] r;
      r = $realtobits($bitstoreal(a) / $bitstoreal(b));
      if (r[62:52] == 11'h7FF && r[51:0] != 52'd0) r = 64'h7FF8000000000000;
      return r;
   endfunction

   function automatic logic [63:0] rand_norm();
      logic        s;
      logic [10:0] e;
      logic [51:0] f;
      s = 1'($urandom_range(0, 1));
      e = 11'($urandom_range(1023 - 200, 1023 + 200));
      f = {20'($urandom), 32'($urandom)};
      return {s, e, f};
   endfunction

   function automatic logic [63:0] rand_op();
      logic [63:0] sp [6];
      sp[0] = 64'h0; sp[1] = 64'h8000000000000000; sp[2] = 64'h7FF0000000000000;
      sp[3] = 64'hFFF0000000000000; sp[4] = 64'h7FF8000000000000;
      sp[5] = 64'h3FF0000000000000;
      if ($urandom_range(0, 7) == 0) return sp[$urandom_range(0, 5)];
      return rand_norm();
   endfunction

   function automatic int next_grant(input logic [N-1:0] m);
      for (int k = 1; k <= N; k++) begin
         int c = (model_last + k) % N;
         if (m[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int c);
      logic [N-1:0] v = '0;
      if (c >= 0) v[c] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [63:0] a, input logic [63:0] b,
                          input logic [TW-1:0] t);
      req_in1[r*BW +: BW] = a;
      req_in2[r*BW +: BW] = b;
      req_tag[r*TW +: TW] = t;
   endtask

   task automatic wait_grant(output logic [N-1:0] g, output bit to);
      g  = '0;
      to = 1'b1;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (|req_ready) begin
            g  = req_ready;
            to = 1'b0;
            tick();
            return;
         end
         tick();
      end
   endtask

   task automatic wait_resp(output int lat, output bit to);
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 60) begin
         tick();
         lat++;
      end
      to = (resp_valid !== 1'b1);
   endtask

   task automatic ack();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '1; resp_ready = 1'b0;
      req_in1 = '0; req_in2 = '0; req_tag = '0;
      tick(); tick();
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (resp_data !== '0 || resp_id !== '0 || resp_tag !== '0) begin
         errors++; $display("FAIL reset_resp got=%h/%0d/%0d exp=0", resp_data, resp_id, resp_tag); end
      rst = 1'b0; req_valid = '0; model_last = N - 1;
   endtask

   task automatic test_single();
      logic [N-1:0] g; bit to; int lat;
      set_req(0, 64'h4018000000000000, 64'h4000000000000000, 5'd3);
      req_valid = 2'b01;
      wait_grant(g, to);
      req_valid = '0;
      checks++; if (to || g !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", g); end
      model_last = 0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
      wait_resp(lat, to);
      checks++; if (to || lat != D + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", lat, D + 1); end
      checks++; if (resp_data !== 64'h4008000000000000) begin
         errors++; $display("FAIL single_data got=%h exp=4008000000000000", resp_data); end
      checks++; if (resp_id !== 0 || resp_tag !== 5'd3) begin
         errors++; $display("FAIL single_idtag got=%0d/%0d exp=0/3", resp_id, resp_tag); end
      ack();
      checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_ack got=%b/%b exp=0/0", resp_valid, busy); end
   endtask

   task automatic test_round_robin();
      int gcyc[$], gidx[$], rid[$];
      logic [63:0] rdat[$];
      logic [TW-1:0] rtag[$];
      logic [63:0] a [N], b [N];
      logic [TW-1:0] t [N];
      int cyc = 0;
      for (int r = 0; r < N; r++) begin
         a[r] = rand_norm(); b[r] = rand_norm(); t[r] = TW'(10 + 11 * r);
         set_req(r, a[r], b[r], t[r]);
      end
      model_last = N - 1;
      rst = 1'b1; tick(); rst = 1'b0;
      req_valid = '1; resp_ready = 1'b1;
      while (rid.size() < 4 && cyc < 100) begin
         if (gidx.size() >= 4) req_valid = '0;
         #1;
         if (|req_ready && gidx.size() < 4) begin
            gcyc.push_back(cyc);
            for (int r = 0; r < N; r++) if (req_ready[r]) gidx.push_back(r);
         end
         if (resp_valid) begin
            rid.push_back(int'(resp_id)); rdat.push_back(resp_data); rtag.push_back(resp_tag);
         end
         tick(); cyc++;
      end
      resp_ready = 1'b0; req_valid = '0;
      checks++; if (gidx.size() != 4 || rid.size() != 4) begin
         errors++; $display("FAIL rr_count got=%0d/%0d exp=4/4", gidx.size(), rid.size()); end
      if (gidx.size() == 4 && rid.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            checks++; if (gidx[k] != k % 2) begin errors++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, gidx[k], k % 2); end
            if (k > 0) begin
               checks++; if (gcyc[k] - gcyc[k-1] != D + 2) begin
                  errors++; $display("FAIL rr_spacing k=%0d got=%0d exp=%0d", k, gcyc[k] - gcyc[k-1], D + 2); end
            end
            checks++; if (rid[k] != gidx[k] || rtag[k] !== t[gidx[k]] || rdat[k] !== ref_div(a[gidx[k]], b[gidx[k]])) begin
               errors++; $display("FAIL rr_resp k=%0d got=%0d/%0d/%h exp=%0d/%0d/%h", k, rid[k], rtag[k], rdat[k],
                                  gidx[k], t[gidx[k]], ref_div(a[gidx[k]], b[gidx[k]])); end
         end
         model_last = gidx[3];
      end
   endtask

   task automatic test_backpressure();
      logic [N-1:0] g; bit to; int lat, e;
      logic [63:0] a [N], b [N];
      logic [TW-1:0] t [N];
      for (int r = 0; r < N; r++) begin
         a[r] = rand_norm(); b[r] = rand_norm(); t[r] = TW'($urandom);
         set_req(r, a[r], b[r], t[r]);
      end
      req_valid = '1;
      e = next_grant('1);
      wait_grant(g, to);
      checks++; if (to || g !== onehot(e)) begin errors++; $display("FAIL bp_grant got=%b exp=%b", g, onehot(e)); end
      model_last = e;
      wait_resp(lat, to);
      checks++; if (to) begin errors++; $display("FAIL bp_timeout got=0 exp=1"); end
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== ref_div(a[e], b[e]) || resp_tag !== t[e] || req_ready !== '0) begin
            errors++; $display("FAIL bp_hold k=%0d got=%b/%h/%0d/%b exp=1/%h/%0d/0", k, resp_valid, resp_data,
                               resp_tag, req_ready, ref_div(a[e], b[e]), t[e]); end
         tick();
      end
      ack();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_clear got=%b exp=0", resp_valid); end
      e = next_grant('1);
      #1;
      checks++; if (req_ready !== onehot(e)) begin errors++; $display("FAIL bp_next got=%b exp=%b", req_ready, onehot(e)); end
      wait_grant(g, to);
      req_valid = '0;
      model_last = e;
      wait_resp(lat, to);
      checks++; if (to || resp_id !== e[0:0] || resp_data !== ref_div(a[e], b[e])) begin
         errors++; $display("FAIL bp_second got=%0d/%h exp=%0d/%h", resp_id, resp_data, e, ref_div(a[e], b[e])); end
      ack();
   endtask

   task automatic test_special();
      logic [63:0] sa [5], sb [5];
      logic [N-1:0] g; bit to; int lat, r;
      sa[0] = 64'h3FF0000000000000; sb[0] = 64'h0;
      sa[1] = 64'h0;                sb[1] = 64'h0;
      sa[2] = 64'hFFF0000000000000; sb[2] = 64'h4000000000000000;
      sa[3] = 64'hC008000000000000; sb[3] = 64'h7FF0000000000000;
      sa[4] = 64'h7FF8000000000000; sb[4] = 64'h3FF0000000000000;
      for (int k = 0; k < 5; k++) begin
         r = $urandom_range(0, N - 1);
         set_req(r, sa[k], sb[k], TW'(k));
         req_valid = onehot(r);
         wait_grant(g, to);
         req_valid = '0;
         model_last = r;
         wait_resp(lat, to);
         checks++; if (to || resp_data !== ref_div(sa[k], sb[k])) begin
            errors++; $display("FAIL special k=%0d got=%h exp=%h", k, resp_data, ref_div(sa[k], sb[k])); end
         if (k == 0) begin
            checks++; if (resp_data !== 64'h7FF0000000000000) begin
               errors++; $display("FAIL special_inf got=%h exp=7ff0000000000000", resp_data); end
         end
         ack();
      end
   endtask

   task automatic test_random();
      logic [N-1:0] g, m; bit to; int lat, e;
      logic [63:0] a [N], b [N];
      logic [TW-1:0] t [N];
      for (int it = 0; it < 30; it++) begin
         for (int r = 0; r < N; r++) begin
            a[r] = rand_op(); b[r] = rand_op(); t[r] = TW'($urandom);
            set_req(r, a[r], b[r], t[r]);
         end
         m = N'($urandom_range(1, (1 << N) - 1));
         req_valid = m;
         e = next_grant(m);
         wait_grant(g, to);
         req_valid = '0;
         checks++; if (to || g !== onehot(e)) begin errors++; $display("FAIL rand_grant it=%0d got=%b exp=%b", it, g, onehot(e)); end
         model_last = e;
         wait_resp(lat, to);
         for (int w = $urandom_range(0, 3); w > 0; w--) tick();
         checks++;
         if (to || resp_id !== e[0:0] || resp_tag !== t[e] || resp_data !== ref_div(a[e], b[e])) begin
            errors++; $display("FAIL rand_resp it=%0d got=%0d/%0d/%h exp=%0d/%0d/%h", it, resp_id, resp_tag,
                               resp_data, e, t[e], ref_div(a[e], b[e])); end
         ack();
      end
   endtask

   task automatic test_reset_busy();
      logic [N-1:0] g; bit to, seen; int lat;
      set_req(1, rand_norm(), rand_norm(), 5'd9);
      req_valid = 2'b10;
      wait_grant(g, to);
      req_valid = '0;
      checks++; if (to || g !== 2'b10) begin errors++; $display("FAIL rstb_grant got=%b exp=10", g); end
      tick();
      rst = 1'b1;
      tick();
      req_valid = '1;
      #1;
      checks++; if (busy !== 1'b0 || req_ready !== '0) begin
         errors++; $display("FAIL rstb_after got=%b/%b exp=0/00", busy, req_ready); end
      tick();
      rst = 1'b0; req_valid = '0; model_last = N - 1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (resp_valid !== 1'b0) seen = 1'b1;
         tick();
      end
      checks++; if (seen) begin errors++; $display("FAIL rstb_discard got=1 exp=0"); end
      set_req(0, 64'h4018000000000000, 64'h4000000000000000, 5'd7);
      req_valid = '1;
      wait_grant(g, to);
      req_valid = '0;
      checks++; if (to || g !== 2'b01) begin errors++; $display("FAIL rstb_first got=%b exp=01", g); end
      model_last = 0;
      wait_resp(lat, to);
      checks++; if (to || lat != D + 1 || resp_data !== 64'h4008000000000000 || resp_id !== 0 || resp_tag !== 5'd7) begin
         errors++; $display("FAIL rstb_resp got=%0d/%h/%0d/%0d exp=%0d/4008000000000000/0/7", lat, resp_data,
                            resp_id, resp_tag, D + 1); end
      ack();
   endtask

`ifdef FPDIV_ARB_FLUSH_EN
   task automatic test_flush();
      logic [N-1:0] g; bit to; int lat, e;
      for (int r = 0; r < N; r++) set_req(r, rand_norm(), rand_norm(), TW'(r));
      req_valid = '1; flush = 1'b1;
      #1;
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL flush_idle got=%b exp=0", req_ready); end
      flush = 1'b0;
      e = next_grant('1);
      wait_grant(g, to);
      req_valid = '0;
      checks++; if (to || g !== onehot(e)) begin errors++; $display("FAIL flush_grant got=%b exp=%b", g, onehot(e)); end
      model_last = e;
      wait_resp(lat, to);
      flush = 1'b1; resp_ready = 1'b1;
      tick();
      flush = 1'b0; resp_ready = 1'b0;
      checks++; if (to || resp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL flush_done got=%b/%b exp=0/0", resp_valid, busy); end
      req_valid = '1;
      e = next_grant('1);
      #1;
      checks++; if (req_ready !== onehot(e)) begin errors++; $display("FAIL flush_next got=%b exp=%b", req_ready, onehot(e)); end
      wait_grant(g, to);
      req_valid = '0;
      model_last = e;
      wait_resp(lat, to);
      ack();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_special();
      test_random();
      test_reset_busy();
`ifdef FPDIV_ARB_FLUSH_EN
      test_flush();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
